// File: rtl/telem_pkg.sv
// Shared definitions for the telemetry framer: sync byte, framer state
// encoding and the constant helpers used to size the datapath.
package telem_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        COUNT = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4
    } telem_state_t;

    // Bytes needed to carry one WIDTH-bit word.
    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, one stop
// bit, each DIV clocks long. ready is also raised in the final cycle of the
// stop bit so a waiting byte follows with no idle gap.
module uart_tx_byte #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int DW = $clog2(DIV);

    logic          active;
    logic [3:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic [7:0]    shreg;
    logic          last_cycle;

    assign last_cycle = active && (bit_cnt == 4'd9) && (div_cnt == '0);
    assign ready      = !active || last_cycle;

    // Bit timer (down-counter per bit) and serialiser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= DW'(DIV - 1);
            shreg   <= data;
            tx      <= 1'b0;
        end else if (active) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end else if (bit_cnt == 4'd9) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                div_cnt <= DW'(DIV - 1);
                if (bit_cnt < 4'd8) begin
                    tx    <= shreg[0];
                    shreg <= {1'b0, shreg[7:1]};
                end else begin
                    tx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// Telemetry framer: snapshots CHANNELS words on a start request and sends
// one framed packet (sync, channel count, data, optional checksum) on a
// UART line.
// Build option: define TELEM_CHECKSUM_EN to append the 8-bit checksum byte.
//
// state | meaning
// IDLE  | waiting for start; also covers the last byte still on the line
// SYNC  | offering the 0xA5 sync byte
// COUNT | offering the channel-count byte
// DATA  | offering snapshot bytes, channel 0 first, MSB first
// CSUM  | offering the checksum byte (checksum builds only)
module telemetry_framer
    import telem_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] values,
    input  logic                      start,
    input  logic                      clear_ovr,
    output logic                      tx,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int NB     = bytes_per_word(WIDTH);
    localparam int DIV    = baud_div(CLK_HZ, BAUD);
    localparam int NBYTES = CHANNELS * NB;
    localparam int SRW    = NBYTES * 8;
    localparam int CW     = $clog2(NBYTES + 1);

    if (DIV < 2) begin : g_bad_div
        $error("telemetry_framer: CLK_HZ/BAUD gives a bit divider below 2");
    end
    if (CHANNELS < 1 || CHANNELS > 255) begin : g_bad_channels
        $error("telemetry_framer: CHANNELS must be within 1..255");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("telemetry_framer: WIDTH must be within 1..32");
    end

    telem_state_t   state_q, state_d;
    logic [SRW-1:0] load_vec;
    logic [SRW-1:0] snap_q;
    logic [CW-1:0]  data_cnt;
    logic [7:0]     data_byte;
    logic           busy_q;
    logic           frame_done_q;
    logic           ovr_q;
    logic           snap_load;
    logic           end_of_frame;
    logic           uart_valid;
    logic           uart_ready;
    logic [7:0]     uart_data;
`ifdef TELEM_CHECKSUM_EN
    logic [7:0]     csum_q;
`endif

    assign data_byte = snap_q[SRW-1 -: 8];

    // Last cycle of the final stop bit: the line becomes free at the next edge.
    assign end_of_frame = busy_q && (state_q == IDLE) && uart_ready;

    // Lay the words out in transmit order, each zero-extended to NB bytes.
    always_comb begin
        load_vec = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            load_vec[(CHANNELS-1-ch)*NB*8 +: WIDTH] = values[ch*WIDTH +: WIDTH];
        end
    end

    // Next state and byte offered to the transmitter.
    always_comb begin
        state_d    = state_q;
        uart_valid = 1'b0;
        uart_data  = SYNC_BYTE;
        snap_load  = 1'b0;
        case (state_q)
            IDLE: begin
                // A request in the end-of-frame cycle is honoured, which gives
                // one idle-high clock between streamed frames.
                if (start && (!busy_q || end_of_frame)) begin
                    state_d   = SYNC;
                    snap_load = 1'b1;
                end
            end
            SYNC: begin
                uart_valid = 1'b1;
                uart_data  = SYNC_BYTE;
                if (uart_ready) state_d = COUNT;
            end
            COUNT: begin
                uart_valid = 1'b1;
                uart_data  = 8'(CHANNELS);
                if (uart_ready) state_d = DATA;
            end
            DATA: begin
                uart_valid = 1'b1;
                uart_data  = data_byte;
                if (uart_ready && data_cnt == '0) begin
`ifdef TELEM_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef TELEM_CHECKSUM_EN
            CSUM: begin
                uart_valid = 1'b1;
                uart_data  = csum_q;
                if (uart_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Snapshot shift register and remaining-data-byte down-counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q   <= '0;
            data_cnt <= '0;
        end else begin
            if (snap_load) begin
                snap_q <= load_vec;
            end else if (state_q == DATA && uart_ready) begin
                snap_q <= snap_q << 8;
            end
            if (state_q == COUNT && uart_ready) begin
                data_cnt <= CW'(NBYTES - 1);
            end else if (state_q == DATA && uart_ready && data_cnt != '0) begin
                data_cnt <= data_cnt - 1'b1;
            end
        end
    end

`ifdef TELEM_CHECKSUM_EN
    // Running sum of the count byte and data bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (state_q == COUNT && uart_ready) begin
            csum_q <= 8'(CHANNELS);
        end else if (state_q == DATA && uart_ready) begin
            csum_q <= csum_q + data_byte;
        end
    end
`endif

    // Busy spans first start bit to last stop bit; frame_done marks its end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= end_of_frame;
            if (state_q == SYNC && uart_ready) begin
                busy_q <= 1'b1;
            end else if (end_of_frame) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Sticky overrun; setting wins over clearing. A request landing in the
    // end-of-frame cycle starts the next frame, so it is not an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= 1'b0;
        end else if (start && busy_q && !end_of_frame) begin
            ovr_q <= 1'b1;
        end else if (clear_ovr) begin
            ovr_q <= 1'b0;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .data  (uart_data),
        .valid (uart_valid),
        .ready (uart_ready),
        .tx    (tx)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: CHANNELS=2, WIDTH=12, DIV=10.
// Frame length follows TELEM_CHECKSUM_EN.
module tb_telemetry_framer;

    localparam int CH     = 2;
    localparam int W      = 12;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 10;
`ifdef TELEM_CHECKSUM_EN
    localparam int F = 7;
`else
    localparam int F = 6;
`endif
    localparam int FRAME_CYC = 10 * DIV * F;

    logic            clk = 1'b0;
    logic            reset;
    logic            start = 1'b0;
    logic            clear_ovr = 1'b0;
    logic [CH*W-1:0] values;
    logic            tx, busy, frame_done, overrun;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          fd_count = 0;
    int          fd0;
    bit          aborted  = 1'b0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_a [0:6];
    logic [7:0]  exp_b [0:6];

    telemetry_framer #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .values     (values),
        .start      (start),
        .clear_ovr  (clear_ovr),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    always @(negedge reset) aborted = 1'b1;

    // Line receiver: samples mid-bit, drops characters hit by reset.
    initial begin
        logic [7:0] rx_byte;
        logic       stop_bit;
        forever begin
            @(negedge tx);
            if (reset !== 1'b1) continue;
            aborted = 1'b0;
            repeat (DIV / 2) @(posedge clk);
            #1;
            if (tx !== 1'b0) continue;
            for (int b = 0; b < 8; b++) begin
                repeat (DIV) @(posedge clk);
                #1;
                rx_byte[b] = tx;
            end
            repeat (DIV) @(posedge clk);
            #1;
            stop_bit = tx;
            if (!aborted && stop_bit === 1'b1) rx_q.push_back(rx_byte);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input bit use_b);
        logic [7:0] e, o;
        check({tag, "_len"}, 32'(rx_q.size()), 32'(F));
        for (int i = 0; i < F; i++) begin
            e = use_b ? exp_b[i] : exp_a[i];
            o = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'h0, o}, {24'h0, e});
        end
        rx_q.delete();
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_done_timeout"}, {31'h0, frame_done}, 32'h1);
    endtask

    initial begin
        exp_a = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEC};
        exp_b = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h10};
        values = {12'hABC, 12'h123};
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) step();

        // reset state
        check("rst_tx",     {31'h0, tx},         32'h1);
        check("rst_busy",   {31'h0, busy},       32'h0);
        check("rst_done",   {31'h0, frame_done}, 32'h0);
        check("rst_ovr",    {31'h0, overrun},    32'h0);
        reset = 1'b1;
        repeat (2) step();

        // single frame with exact timing
        start = 1'b1;
        step();
        start = 1'b0;
        check("f1_k_busy", {31'h0, busy}, 32'h0);
        check("f1_k_tx",   {31'h0, tx},   32'h1);
        step();
        check("f1_k1_busy", {31'h0, busy}, 32'h1);
        check("f1_k1_tx",   {31'h0, tx},   32'h0);
        repeat (FRAME_CYC - 1) step();
        check("f1_pre_done", {31'h0, frame_done}, 32'h0);
        check("f1_pre_busy", {31'h0, busy},       32'h1);
        step();
        check("f1_done",      {31'h0, frame_done}, 32'h1);
        check("f1_done_busy", {31'h0, busy},       32'h0);
        check("f1_done_tx",   {31'h0, tx},         32'h1);
        step();
        check("f1_done_pulse", {31'h0, frame_done}, 32'h0);
        check_frame("f1", 1'b0);
        check("f1_ovr", {31'h0, overrun}, 32'h0);

        // continuous streaming, values change mid-frame
        start = 1'b1;
        repeat (200) step();
        values = {12'hFFF, 12'h000};
        wait_done("c1", FRAME_CYC);
        check("c_gap_tx",   {31'h0, tx},   32'h1);
        check("c_gap_busy", {31'h0, busy}, 32'h0);
        step();
        check("c_next_tx",   {31'h0, tx},         32'h0);
        check("c_next_busy", {31'h0, busy},       32'h1);
        check("c_next_done", {31'h0, frame_done}, 32'h0);
        start = 1'b0;
        check_frame("c1", 1'b0);
        wait_done("c2", FRAME_CYC + 10);
        step();
        check_frame("c2", 1'b1);
        check("c_ovr", {31'h0, overrun}, 32'h1);
        clear_ovr = 1'b1;
        step();
        clear_ovr = 1'b0;
        check("c_ovr_clr", {31'h0, overrun}, 32'h0);

        // overrun behaviour
        fd0 = fd_count;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        check("o_pre", {31'h0, overrun}, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("o_set", {31'h0, overrun}, 32'h1);
        repeat (20) step();
        check("o_sticky", {31'h0, overrun}, 32'h1);
        clear_ovr = 1'b1;
        step();
        clear_ovr = 1'b0;
        check("o_clr", {31'h0, overrun}, 32'h0);
        start = 1'b1;
        clear_ovr = 1'b1;
        step();
        start = 1'b0;
        clear_ovr = 1'b0;
        check("o_prio", {31'h0, overrun}, 32'h1);
        clear_ovr = 1'b1;
        step();
        clear_ovr = 1'b0;
        check("o_clr2", {31'h0, overrun}, 32'h0);
        wait_done("o", FRAME_CYC);
        step();
        check_frame("o", 1'b1);
        repeat (60) step();
        check("o_no_extra_busy",  {31'h0, busy},    32'h0);
        check("o_no_extra_bytes", 32'(rx_q.size()), 32'h0);
        check("o_done_count",     32'(fd_count),    32'(fd0 + 1));

        // reset during the third data byte
        values = {12'hABC, 12'h123};
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (450) step();
        fd0 = fd_count;
        reset = 1'b0;
        #1;
        check("ra_tx",   {31'h0, tx},         32'h1);
        check("ra_busy", {31'h0, busy},       32'h0);
        check("ra_done", {31'h0, frame_done}, 32'h0);
        repeat (1000) step();
        check("ra_no_done",     32'(fd_count),    32'(fd0));
        check("ra_partial_len", 32'(rx_q.size()), 32'h4);
        rx_q.delete();
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        check("ra_restart_tx", {31'h0, tx}, 32'h0);
        wait_done("ra", FRAME_CYC + 10);
        step();
        check_frame("ra", 1'b0);
        check("ra_done_count", 32'(fd_count), 32'(fd0 + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/telemetry_framer.md
# telemetry_framer

Multi-channel measurement streamer that replaces the per-value fixed UART senders with a single framed serial link. On a start request it snapshots CHANNELS measurement words (counter, duty-cycle and similar sensor outputs), then transmits one framed packet on a UART line: sync byte, channel count, data bytes and an optional checksum. It sits between the measurement circuits and the board UART pin, and produces one self-delimiting stream that a host can parse regardless of channel count or width.

## Interface
- CHANNELS, 2, number of input words, 1..255
- WIDTH, 8, bits per word, 1..32; NB = ceil(WIDTH/8) bytes per word
- CLK_HZ, 100_000_000, clock frequency
- BAUD, 115200, line rate; DIV = round(CLK_HZ/BAUD), must be ≥ 2
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- values  in  CHANNELS*WIDTH  packed words; channel i at [i*WIDTH +: WIDTH]
- start  in  1  frame request, level-sampled in IDLE; tie high for continuous streaming
- clear_ovr  in  1  synchronous clear of overrun
- tx  out  1  UART output, idle high
- busy  out  1  high while a frame is in flight
- frame_done  out  1  one-cycle pulse at end of last stop bit
- overrun  out  1  sticky: start was high while busy

## Operation
- FSM states: IDLE, SYNC, COUNT, DATA, CSUM. Transition IDLE→SYNC on start; SYNC→COUNT; COUNT→DATA; DATA→CSUM after CHANNELS*NB bytes, or DATA→IDLE when checksum is compiled out; CSUM→IDLE.
- Each state transition occurs when the byte transmitter accepts the current byte (valid/ready handshake).
- Snapshot: all values are registered on the edge where IDLE samples start. Input changes during the frame have no effect.
- Byte order:
  - 0xA5
  - CHANNELS[7:0]
  - channel 0 first through channel CHANNELS-1; within a channel, most-significant byte first
  - each word is zero-extended to NB*8 bits
- Checksum: 8-bit sum mod 256 of the count byte and all data bytes; the sync byte is excluded.
- UART character format: start bit 0, 8 data bits LSB first, 1 stop bit. Each bit lasts DIV cycles.
- overrun: set when start=1 and busy=1. The request is ignored and does not queue. clear_ovr clears it; set takes priority if both occur in the same cycle.
- Reset values: tx=1, busy=0, frame_done=0, overrun=0, FSM=IDLE, snapshot=0. An assertion mid-frame aborts immediately (tx high asynchronously); there is no resume after release.

## Timing
- start sampled high in IDLE at edge k → busy=1 and tx=0 (start bit) from edge k+1.
- Bytes are sent back-to-back with no idle gap. Frame length is F = 2 + CHANNELS*NB (+1 with checksum) bytes = 10*DIV*F cycles.
- frame_done pulses and busy falls in the same cycle, at edge k+1+10*DIV*F. IDLE samples start in that cycle, so continuous streaming inserts exactly one idle-high clk between frames.
- overrun is flagged from the edge after the offending cycle.
- frame_done never pulses for a frame aborted by reset.

## Configuration
- TELEM_CHECKSUM_EN defined: the CSUM state and checksum byte are present (F includes +1).
- TELEM_CHECKSUM_EN undefined: no checksum logic; DATA→IDLE directly; frame ends after the last data byte.

## Structure
- Shared package telem_pkg holds:
  - SYNC_BYTE = 8'hA5
  - FSM state enum
  - bytes_per_word(WIDTH) and baud_div(CLK_HZ, BAUD) constant functions
- Sub-module uart_tx_byte (parameter DIV; ports clk, reset, data[7:0], valid, ready, tx) does bit timing and serialisation only. The framer owns sequencing, snapshot, checksum and flags.
- Elaboration error on DIV<2, CHANNELS∉1..255 or WIDTH∉1..32.

## Test plan
All scenarios use CHANNELS=2, WIDTH=12, CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), TELEM_CHECKSUM_EN defined.
- values={0xABC,0x123} (ch1,ch0), one-cycle start → bytes A5 02 01 23 0A BC EC; frame_done at 10*10*7+1=701 cycles after start edge.
- start tied high → consecutive identical frames with exactly one idle-high clk between stop bit and next start bit.
- Change values to {0xFFF,0x000} mid-frame → current frame still carries 01 23 0A BC; next frame carries 00 00 0F FF, checksum 0x10.
- start pulse while busy → overrun=1 and stays high, no extra frame; clear_ovr pulse → 0; start and clear_ovr together while busy → overrun stays 1.
- reset asserted during the third data byte → tx=1 immediately, busy=0, no frame_done; after release with start=1 → complete fresh frame starting with A5.
- Rebuild without TELEM_CHECKSUM_EN → 6-byte frame A5 02 01 23 0A BC; frame_done at 601 cycles.
